// File: rtl/data_bus_pkg.sv
// data_bus_pkg: size encodings, controller states and lane/alignment/extension helpers.
package data_bus_pkg;
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP, S_ERR} state_t;

   // Mask of 2^size lanes starting at lane off, sized for the widest (8-lane) bus.
   function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
      logic [15:0] m;
      m = (16'd1 << (4'd1 << size)) - 16'd1;
      return 8'(m << off);
   endfunction

   function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] a, input logic dw64);
      return size == SZ_B ? 1'b1 :
             size == SZ_H ? a[0] == 1'b0 :
             size == SZ_W ? a[1:0] == 2'b00 :
             dw64 && a == 3'b000;
   endfunction

   function automatic logic [63:0] load_ext(input logic [63:0] d, input logic [1:0] size, input logic uns);
      return size == SZ_B ? {{56{~uns & d[7]}}, d[7:0]} :
             size == SZ_H ? {{48{~uns & d[15]}}, d[15:0]} :
             size == SZ_W ? {{32{~uns & d[31]}}, d[31:0]} :
             d;
   endfunction
endpackage

// File: rtl/data_bus_ctrl_ram.sv
// data_bus_ram: synchronous single-port RAM with per-byte write enables and registered read.
module data_bus_ram #(
   parameter int DEPTH = 16384,
   parameter int DW = 32,
   parameter int AW = 14
) (
   input  logic            clk,
   input  logic            en,
   input  logic [DW/8-1:0] be,
   input  logic [AW-1:0]   addr,
   input  logic [DW-1:0]   wdata,
   output logic [DW-1:0]   rdata
);
   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < DW / 8; i++)
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         rdata <= mem[addr];
      end
   end
endmodule

// File: rtl/data_bus_ctrl.sv
// data_bus_ctrl: handshaked byte-addressed data-memory controller with wait states,
// byte-lane stores, extended sub-word loads and alignment checking.
module data_bus_ctrl
   import data_bus_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req,
   input  logic                  we,
   input  logic [1:0]            size,
   input  logic                  unsigned_value,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  ready,
   output logic                  done,
   output logic                  err,
   output logic [DATA_WIDTH-1:0] rdata
);
   localparam int LANES = DATA_WIDTH / 8;
   localparam int LB = $clog2(LANES);
   localparam int DEPTH = 2 ** (ADDR_WIDTH - LB);

   state_t state;
   logic we_q, uns_q;
   logic [1:0] size_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q, rdata_q, dout, load_val;
   logic [3:0] cnt;
   logic [LB-1:0] off;
   logic [7:0] mask8;
   logic [LANES-1:0] be;
   logic valid;

   assign off = addr_q[LB-1:0];
   assign mask8 = lane_mask(size_q, 3'(off));
   assign be = (state == S_ACCESS && we_q) ? LANES'(mask8) : '0;
   assign valid = is_aligned(size, addr[2:0], DATA_WIDTH == 64);
   assign load_val = DATA_WIDTH'(load_ext(64'(dout >> {off, 3'b000}), size_q, uns_q));
   // The RAM read is registered, so the load result is steered straight out during RESP.
   assign rdata = (state == S_RESP && !we_q) ? load_val : rdata_q;

   data_bus_ram #(.DEPTH(DEPTH), .DW(DATA_WIDTH), .AW(ADDR_WIDTH - LB)) u_ram (
      .clk  (clk),
      .en   (state == S_ACCESS),
      .be   (be),
      .addr (addr_q[ADDR_WIDTH-1:LB]),
      .wdata(wdata_q << {off, 3'b000}),
      .rdata(dout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         ready   <= 1'b1;
         done    <= 1'b0;
         err     <= 1'b0;
         rdata_q <= '0;
         cnt     <= '0;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         size_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         case (state)
            S_IDLE:
               if (req) begin
                  we_q    <= we;
                  uns_q   <= unsigned_value;
                  size_q  <= size;
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  ready   <= 1'b0;
                  if (!valid) begin
                     state <= S_ERR;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else if (WAIT_STATES > 0) begin
                     state <= S_WAIT;
                     cnt   <= 4'(WAIT_STATES - 1);
                  end else
                     state <= S_ACCESS;
               end
            S_WAIT:
               if (cnt == 4'd0) state <= S_ACCESS;
               else cnt <= cnt - 4'd1;
            S_ACCESS: begin
               state <= S_RESP;
               done  <= 1'b1;
            end
            S_RESP: begin
               state <= S_IDLE;
               done  <= 1'b0;
               ready <= 1'b1;
               if (!we_q) rdata_q <= load_val;
            end
            default: begin
               state <= S_IDLE;
               done  <= 1'b0;
               err   <= 1'b0;
               ready <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: doc/data_bus_ctrl.md
# data_bus_ctrl

Parametrised data-memory controller for the core's load/store unit. It replaces the single-cycle, always-ready data bus with a handshaked, byte-addressed RAM. Features: true byte-lane writes at any offset, sign/zero-extended sub-word reads, alignment checking and configurable wait states. It sits between the LSU and on-chip data RAM and is the template for slower external memories.

## Interface
- ADDR_WIDTH, 16, byte address width.
- DATA_WIDTH, 32, word width; legal values 32 or 64.
- WAIT_STATES, 0, extra cycles inserted between request acceptance and memory access (0..15).
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  1  request valid.
- we  input  1  1 = store, 0 = load; sampled with req.
- size  input  2  00 byte, 01 half, 10 word, 11 doubleword (DATA_WIDTH=64 only).
- unsigned_value  input  1  load zero-extends when 1, sign-extends when 0.
- addr  input  ADDR_WIDTH  byte address.
- wdata  input  DATA_WIDTH  store data, right-aligned (bits [8·n-1:0] used).
- ready  output  1  controller idle, request accepted this cycle if req=1.
- done  output  1  one-cycle completion pulse for every accepted request.
- err  output  1  coincides with done; misaligned or illegal size, no memory access.
- rdata  output  DATA_WIDTH  load result, valid when done=1 and we was 0.

## Operation
- LANES = DATA_WIDTH/8, LB = log2(LANES), DEPTH = 2^(ADDR_WIDTH-LB) words exactly.
- Word index = addr[ADDR_WIDTH-1:LB], lane offset = addr[LB-1:0].
- Request captured (we, size, unsigned_value, addr, wdata) on the edge where req && ready; inputs are don't-care otherwise.
- Alignment: half needs addr[0]=0, word addr[1:0]=0, dword addr[2:0]=0. size=11 with DATA_WIDTH=32 is illegal.
- Misaligned/illegal: no RAM write or read, done=1 and err=1, rdata unchanged.
- Store: byte-enable mask of 2^size lanes starting at lane offset; wdata low bytes shifted left by 8·offset; untouched lanes keep their contents.
- Load: extract 2^size bytes at offset, right-align, then extend to DATA_WIDTH by MSB (signed) or zeros (unsigned_value=1); full-width loads are not extended.
- FSM states:
  - IDLE: ready=1. Accept goes to ERR if invalid, WAIT if WAIT_STATES>0, otherwise ACCESS.
  - WAIT: counter loaded with WAIT_STATES-1 and decremented; at 0 goes to ACCESS.
  - ACCESS: RAM read/write issued, goes to RESP.
  - RESP: done=1 (rdata valid), returns to IDLE.
  - ERR: done=1, err=1, returns to IDLE.
- Store followed by load to the same word returns the new data (RAM write completes in ACCESS before the next acceptance).

## Timing
- Reset values: ready=1, done=0, err=0, rdata=0, FSM=IDLE, wait counter=0. RAM contents are not reset.
- Valid request latency, accept edge to done: 2 + WAIT_STATES cycles. Next accept occurs no earlier than the cycle after done, giving throughput of 1 per 3+WAIT_STATES cycles.
- Invalid request: done/err asserted 1 cycle after accept.
- ready drops the cycle after accept and rises in the cycle after done.
- req held high while ready=0 is ignored; there is no queueing.
- Reset asserted mid-operation: FSM returns to IDLE immediately. A store is performed only if the ACCESS edge occurred before reset; no done pulse follows.
- rdata holds its value until the next successful load.

## Structure
- Package data_bus_pkg holds the size encodings SZ_B/SZ_H/SZ_W/SZ_D, the FSM state enum, and the functions for lane mask, alignment check and load extension.
- Sub-module data_bus_ram: synchronous single-port RAM, DEPTH×DATA_WIDTH, per-byte write enables, registered read. The controller holds the FSM, capture registers and lane steering.

## Test plan
- Byte stores: 0x11,0x22,0x33,0x44 to addr 0..3, then word load at 0 -> rdata=0x44332211, done 2 cycles after accept (WAIT_STATES=0).
- Signed/unsigned: store 0x80 at addr 5; signed byte load -> 0xFFFFFF80, unsigned -> 0x00000080; half 0x8001 at addr 6 signed -> 0xFFFF8001.
- Misaligned: word load at addr 2 -> done=err=1 one cycle after accept, RAM and rdata unchanged. size=11 with DATA_WIDTH=32 -> err.
- WAIT_STATES=3: load latency 5 cycles; req held during busy is ignored, with exactly one done per accept.
- Reset during WAIT of a store to addr 0x10: done never pulses, a subsequent load of 0x10 returns the old data, ready=1 after reset.
- DATA_WIDTH=64: dword store at 0x8 then byte load at 0xF signed returns the top byte sign-extended to 64 bits.
